// File: rtl/fix_recursion_bank.sv
// Time-multiplexed bank of N_CH complex recursions y_c = x_c + L_c*y_c[k-1] on one 2-stage MAC.
// Optional feature: define FIXREC_SAT_EN for saturating W-reductions and a live sat_flag.
module fix_recursion_bank #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned n_int  = 8,
    parameter int unsigned n_mant = 23,
    localparam int unsigned W     = n_int + n_mant + 1,
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            coef_we,
    input  logic [CH_W-1:0] coef_ch,
    input  logic [W-1:0]    coefR,
    input  logic [W-1:0]    coefI,
    input  logic            seed_we,
    input  logic [CH_W-1:0] seed_ch,
    input  logic [W-1:0]    seedR,
    input  logic [W-1:0]    seedI,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    inR,
    input  logic [W-1:0]    inI,
    output logic            out_valid,
    output logic [CH_W-1:0] out_ch,
    output logic [W-1:0]    outR,
    output logic [W-1:0]    outI,
    output logic            sat_flag
);

    localparam int unsigned DEPTH = 1 << CH_W;
    localparam int unsigned MW    = 2 * W;
    localparam int unsigned PW    = 2 * W + 1;
    localparam int unsigned SW    = W + 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    // Reduce a wide signed value to W bits; MSB of the result flags a clamp.
    function automatic logic [W:0] reduce_w(input logic signed [PW-1:0] v);
        logic signed [W-1:0] lo;
        lo = v[W-1:0];
`ifdef FIXREC_SAT_EN
        if (v != PW'(lo)) begin
            return {1'b1, v[PW-1], {(W-1){~v[PW-1]}}};
        end
`endif
        return {1'b0, lo};
    endfunction

    logic [W-1:0]    lr_q [DEPTH];
    logic [W-1:0]    li_q [DEPTH];
    logic [W-1:0]    yr_q [DEPTH];
    logic [W-1:0]    yi_q [DEPTH];

    logic [CH_W-1:0] ch_cnt_q, ch_cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            v1_q, kill1_q, kill_d;
    logic [CH_W-1:0] ch1_q;
    logic [W-1:0]    pr_q, pi_q, xr_q, xi_q;
    logic            out_valid_q;
    logic [CH_W-1:0] out_ch_q;
    logic [W-1:0]    outr_q, outi_q;
    logic            sat_q, sat_d;

    logic                  accept_c;
    logic signed [W-1:0]   ar, ai, br, bi;
    logic signed [MW-1:0]  m_rr, m_ii, m_ri, m_ir;
    logic signed [PW-1:0]  re_sh, im_sh;
    logic signed [SW-1:0]  s_r, s_i;
    logic [W:0]            p_red_r, p_red_i, s_red_r, s_red_i;

    // Channel sequencing, hazard look-ahead and seed-over-stage-1 kill.
    always_comb begin
        accept_c = in_valid && in_ready_q;
        ch_cnt_d = ch_cnt_q;
        if (accept_c) begin
            ch_cnt_d = (ch_cnt_q == LAST_CH) ? '0 : ch_cnt_q + CH_W'(1);
        end
        in_ready_d = !(accept_c && (ch_cnt_d == ch_cnt_q));
        kill_d     = accept_c && seed_we && (seed_ch == ch_cnt_q);
    end

    // Stage 1 complex multiply, stage 2 add, plus clamp detection.
    always_comb begin
        ar      = lr_q[ch_cnt_q];
        ai      = li_q[ch_cnt_q];
        br      = yr_q[ch_cnt_q];
        bi      = yi_q[ch_cnt_q];
        m_rr    = MW'(ar) * MW'(br);
        m_ii    = MW'(ai) * MW'(bi);
        m_ri    = MW'(ar) * MW'(bi);
        m_ir    = MW'(ai) * MW'(br);
        re_sh   = (PW'(m_rr) - PW'(m_ii)) >>> n_mant;
        im_sh   = (PW'(m_ri) + PW'(m_ir)) >>> n_mant;
        p_red_r = reduce_w(re_sh);
        p_red_i = reduce_w(im_sh);
        s_r     = SW'($signed(pr_q)) + SW'($signed(xr_q));
        s_i     = SW'($signed(pi_q)) + SW'($signed(xi_q));
        s_red_r = reduce_w(PW'(s_r));
        s_red_i = reduce_w(PW'(s_i));
        sat_d   = sat_q
                | (accept_c && (p_red_r[W] || p_red_i[W]))
                | (v1_q && (s_red_r[W] || s_red_i[W]));
    end

    // Coefficients survive clear; only rst wipes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            lr_q <= '{default: '0};
            li_q <= '{default: '0};
        end else if (!clear && coef_we) begin
            lr_q[coef_ch] <= coefR;
            li_q[coef_ch] <= coefI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            yr_q        <= '{default: '0};
            yi_q        <= '{default: '0};
            ch_cnt_q    <= '0;
            in_ready_q  <= 1'b1;
            v1_q        <= 1'b0;
            kill1_q     <= 1'b0;
            ch1_q       <= '0;
            pr_q        <= '0;
            pi_q        <= '0;
            xr_q        <= '0;
            xi_q        <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            outr_q      <= '0;
            outi_q      <= '0;
            sat_q       <= 1'b0;
        end else begin
            ch_cnt_q    <= ch_cnt_d;
            in_ready_q  <= in_ready_d;
            v1_q        <= accept_c;
            kill1_q     <= kill_d;
            ch1_q       <= ch_cnt_q;
            pr_q        <= p_red_r[W-1:0];
            pi_q        <= p_red_i[W-1:0];
            xr_q        <= inR;
            xi_q        <= inI;
            out_valid_q <= v1_q;
            sat_q       <= sat_d;
            if (v1_q) begin
                out_ch_q <= ch1_q;
                outr_q   <= s_red_r[W-1:0];
                outi_q   <= s_red_i[W-1:0];
            end
            if (v1_q && !kill1_q) begin
                yr_q[ch1_q] <= s_red_r[W-1:0];
                yi_q[ch1_q] <= s_red_i[W-1:0];
            end
            // Seed is written last so it beats a coincident writeback.
            if (seed_we) begin
                yr_q[seed_ch] <= seedR;
                yi_q[seed_ch] <= seedI;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign outR      = outr_q;
    assign outI      = outi_q;
    assign sat_flag  = sat_q;

endmodule
